// File: rtl/axi4_burst_memory_slave.sv
// AXI4 burst memory slave: FIXED/INCR/WRAP bursts into a DATA_WIDTH-wide word array.
// Latency: AW->W accept next cycle; AR handshake in cycle N presents beat 0 in cycle N+1.
// Backpressure: R outputs held stable while rready=0; bvalid held until bready.
//
// Ports: ACLK/ARESETN (async active-low); S_AXI_aw*/w*/b* write channels; S_AXI_ar*/r* read
// channels. Whole-burst SLVERR is decided at the address handshake; wlast misplacement
// additionally marks the write response as SLVERR but the data is still stored.
module axi4_burst_memory_slave #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ID_WIDTH   = 4,
    parameter int                    MEM_DEPTH  = 1024,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
    input  logic                    ACLK,
    input  logic                    ARESETN,
    input  logic [ID_WIDTH-1:0]     S_AXI_awid,
    input  logic [ADDR_WIDTH-1:0]   S_AXI_awaddr,
    input  logic [7:0]              S_AXI_awlen,
    input  logic [2:0]              S_AXI_awsize,
    input  logic [1:0]              S_AXI_awburst,
    input  logic                    S_AXI_awvalid,
    output logic                    S_AXI_awready,
    input  logic [DATA_WIDTH-1:0]   S_AXI_wdata,
    input  logic [DATA_WIDTH/8-1:0] S_AXI_wstrb,
    input  logic                    S_AXI_wlast,
    input  logic                    S_AXI_wvalid,
    output logic                    S_AXI_wready,
    output logic [ID_WIDTH-1:0]     S_AXI_bid,
    output logic [1:0]              S_AXI_bresp,
    output logic                    S_AXI_bvalid,
    input  logic                    S_AXI_bready,
    input  logic [ID_WIDTH-1:0]     S_AXI_arid,
    input  logic [ADDR_WIDTH-1:0]   S_AXI_araddr,
    input  logic [7:0]              S_AXI_arlen,
    input  logic [2:0]              S_AXI_arsize,
    input  logic [1:0]              S_AXI_arburst,
    input  logic                    S_AXI_arvalid,
    output logic                    S_AXI_arready,
    output logic [ID_WIDTH-1:0]     S_AXI_rid,
    output logic [DATA_WIDTH-1:0]   S_AXI_rdata,
    output logic [1:0]              S_AXI_rresp,
    output logic                    S_AXI_rlast,
    output logic                    S_AXI_rvalid,
    input  logic                    S_AXI_rready
);

    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int ALIGN  = $clog2(STRB_W);
    localparam int IDX_W  = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    // Extended width so range arithmetic near the top of the address space cannot overflow.
    localparam int EW     = ADDR_WIDTH + 16;
    localparam logic [EW-1:0] MEM_BYTES = EW'(MEM_DEPTH) * EW'(STRB_W);
    localparam logic [EW-1:0] BASE_EXT  = EW'(BASE_ADDR);
    localparam logic [2:0]    MAX_SIZE  = 3'(ALIGN);

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_WRAP  = 2'b10;
    localparam logic [1:0] BURST_RSVD  = 2'b11;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic       {R_IDLE, R_DATA}         r_state_t;

    // Whole-burst legality: burst type, wrap length, size, and the lowest/highest beat
    // addresses against the memory window (beat addresses are monotonic within a burst).
    function automatic logic burst_bad(input logic [ADDR_WIDTH-1:0] addr, input logic [7:0] len,
                                       input logic [2:0] size, input logic [1:0] burst);
        logic [EW-1:0] a, bytes, total, lo, hi;
        logic          bad;
        a     = EW'(addr);
        bytes = EW'(1) << size;
        total = bytes * (EW'(len) + EW'(1));
        lo    = a;
        hi    = a;
        bad   = (burst == BURST_RSVD) || (size > MAX_SIZE);
        if (burst == BURST_WRAP && !(len inside {8'd1, 8'd3, 8'd7, 8'd15}))
            bad = 1'b1;
        if (burst == 2'b01)
            hi = (a & ~(bytes - EW'(1))) + EW'(len) * bytes;
        if (burst == BURST_WRAP) begin
            lo = a & ~(total - EW'(1));
            hi = lo + total - bytes;
        end
        if (lo < BASE_EXT || hi >= BASE_EXT + MEM_BYTES)
            bad = 1'b1;
        return bad;
    endfunction

    // Address of the beat following 'a'. After the first beat INCR/WRAP run size-aligned.
    function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] a,
                                                        input logic [7:0] len,
                                                        input logic [2:0] size,
                                                        input logic [1:0] burst);
        logic [ADDR_WIDTH-1:0] bytes, total, wrap_base, nxt;
        bytes     = ADDR_WIDTH'(1) << size;
        total     = bytes * (ADDR_WIDTH'(len) + ADDR_WIDTH'(1));
        wrap_base = a & ~(total - ADDR_WIDTH'(1));
        nxt       = (a & ~(bytes - ADDR_WIDTH'(1))) + bytes;
        if (burst == BURST_FIXED)
            nxt = a;
        else if (burst == BURST_WRAP && nxt == wrap_base + total)
            nxt = wrap_base;
        return nxt;
    endfunction

    function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_WIDTH-1:0] a);
        return IDX_W'((a - BASE_ADDR) >> ALIGN);
    endfunction

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    // ---------------- write channel ----------------
    w_state_t              w_state, w_state_nxt;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic [7:0]            w_len, w_cnt;
    logic [2:0]            w_size;
    logic [1:0]            w_burst;
    logic                  w_err, w_proto_err;
    logic                  w_hs, w_last_beat, wlast_bad, aw_bad;

    assign w_hs        = (w_state == W_DATA) && S_AXI_wvalid;
    assign w_last_beat = (w_cnt == w_len);
    assign wlast_bad   = (S_AXI_wlast != w_last_beat);
    assign aw_bad      = burst_bad(S_AXI_awaddr, S_AXI_awlen, S_AXI_awsize, S_AXI_awburst);

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) w_state <= W_IDLE;
        else          w_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt   = w_state;
        S_AXI_awready = 1'b0;
        S_AXI_wready  = 1'b0;
        S_AXI_bvalid  = 1'b0;
        case (w_state)
            W_IDLE: begin
                S_AXI_awready = 1'b1;
                if (S_AXI_awvalid) w_state_nxt = W_DATA;
            end
            W_DATA: begin
                S_AXI_wready = 1'b1;
                if (S_AXI_wvalid && w_last_beat) w_state_nxt = W_RESP;
            end
            W_RESP: begin
                S_AXI_bvalid = 1'b1;
                if (S_AXI_bready) w_state_nxt = W_IDLE;
            end
            default: w_state_nxt = W_IDLE;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            w_addr      <= '0;
            w_len       <= '0;
            w_cnt       <= '0;
            w_size      <= '0;
            w_burst     <= '0;
            w_err       <= 1'b0;
            w_proto_err <= 1'b0;
            S_AXI_bid   <= '0;
            S_AXI_bresp <= RESP_OKAY;
        end else begin
            if (w_state == W_IDLE && S_AXI_awvalid) begin
                S_AXI_bid   <= S_AXI_awid;
                w_addr      <= S_AXI_awaddr;
                w_len       <= S_AXI_awlen;
                w_size      <= S_AXI_awsize;
                w_burst     <= S_AXI_awburst;
                w_cnt       <= '0;
                w_err       <= aw_bad;
                w_proto_err <= 1'b0;
            end
            if (w_hs) begin
                w_addr <= next_addr(w_addr, w_len, w_size, w_burst);
                w_cnt  <= w_cnt + 8'd1;
                if (w_last_beat)
                    S_AXI_bresp <= (w_err || w_proto_err || wlast_bad) ? RESP_SLVERR : RESP_OKAY;
                else
                    w_proto_err <= w_proto_err | wlast_bad;
            end
        end
    end

    // Memory has no reset so contents survive ARESETN.
    always_ff @(posedge ACLK) begin
        if (w_hs && !w_err) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (S_AXI_wstrb[b])
                    mem[word_idx(w_addr)][8*b +: 8] <= S_AXI_wdata[8*b +: 8];
            end
        end
    end

    // ---------------- read channel ----------------
    r_state_t              r_state, r_state_nxt;
    logic [ADDR_WIDTH-1:0] r_addr, r_nxt;
    logic [7:0]            r_len, r_cnt;
    logic [2:0]            r_size;
    logic [1:0]            r_burst;
    logic                  r_err, ar_bad;

    assign ar_bad = burst_bad(S_AXI_araddr, S_AXI_arlen, S_AXI_arsize, S_AXI_arburst);
    assign r_nxt  = next_addr(r_addr, r_len, r_size, r_burst);

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) r_state <= R_IDLE;
        else          r_state <= r_state_nxt;
    end

    always_comb begin
        r_state_nxt   = r_state;
        S_AXI_arready = 1'b0;
        S_AXI_rvalid  = 1'b0;
        case (r_state)
            R_IDLE: begin
                S_AXI_arready = 1'b1;
                if (S_AXI_arvalid) r_state_nxt = R_DATA;
            end
            R_DATA: begin
                S_AXI_rvalid = 1'b1;
                if (S_AXI_rready && S_AXI_rlast) r_state_nxt = R_IDLE;
            end
            default: r_state_nxt = R_IDLE;
        endcase
    end

    // rdata is registered straight from the array, so a same-cycle write to the same
    // word lands after the read sample and the read returns the old contents.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_addr      <= '0;
            r_len       <= '0;
            r_cnt       <= '0;
            r_size      <= '0;
            r_burst     <= '0;
            r_err       <= 1'b0;
            S_AXI_rid   <= '0;
            S_AXI_rdata <= '0;
            S_AXI_rresp <= RESP_OKAY;
            S_AXI_rlast <= 1'b0;
        end else if (r_state == R_IDLE && S_AXI_arvalid) begin
            S_AXI_rid   <= S_AXI_arid;
            r_addr      <= S_AXI_araddr;
            r_len       <= S_AXI_arlen;
            r_size      <= S_AXI_arsize;
            r_burst     <= S_AXI_arburst;
            r_cnt       <= '0;
            r_err       <= ar_bad;
            S_AXI_rdata <= ar_bad ? '0 : mem[word_idx(S_AXI_araddr)];
            S_AXI_rresp <= ar_bad ? RESP_SLVERR : RESP_OKAY;
            S_AXI_rlast <= (S_AXI_arlen == 8'd0);
        end else if (r_state == R_DATA && S_AXI_rready) begin
            if (S_AXI_rlast) begin
                S_AXI_rlast <= 1'b0;
            end else begin
                r_addr      <= r_nxt;
                r_cnt       <= r_cnt + 8'd1;
                S_AXI_rdata <= r_err ? '0 : mem[word_idx(r_nxt)];
                S_AXI_rlast <= ((r_cnt + 8'd1) == r_len);
            end
        end
    end

endmodule

// File: tb/tb_axi4_burst_memory_slave.sv
module tb_axi4_burst_memory_slave;

    logic        ACLK = 1'b0;
    logic        ARESETN;
    logic [3:0]  S_AXI_awid;
    logic [31:0] S_AXI_awaddr;
    logic [7:0]  S_AXI_awlen;
    logic [2:0]  S_AXI_awsize;
    logic [1:0]  S_AXI_awburst;
    logic        S_AXI_awvalid, S_AXI_awready;
    logic [31:0] S_AXI_wdata;
    logic [3:0]  S_AXI_wstrb;
    logic        S_AXI_wlast, S_AXI_wvalid, S_AXI_wready;
    logic [3:0]  S_AXI_bid;
    logic [1:0]  S_AXI_bresp;
    logic        S_AXI_bvalid, S_AXI_bready;
    logic [3:0]  S_AXI_arid;
    logic [31:0] S_AXI_araddr;
    logic [7:0]  S_AXI_arlen;
    logic [2:0]  S_AXI_arsize;
    logic [1:0]  S_AXI_arburst;
    logic        S_AXI_arvalid, S_AXI_arready;
    logic [3:0]  S_AXI_rid;
    logic [31:0] S_AXI_rdata;
    logic [1:0]  S_AXI_rresp;
    logic        S_AXI_rlast, S_AXI_rvalid, S_AXI_rready;

    axi4_burst_memory_slave dut (
        .ACLK(ACLK), .ARESETN(ARESETN),
        .S_AXI_awid(S_AXI_awid), .S_AXI_awaddr(S_AXI_awaddr), .S_AXI_awlen(S_AXI_awlen),
        .S_AXI_awsize(S_AXI_awsize), .S_AXI_awburst(S_AXI_awburst),
        .S_AXI_awvalid(S_AXI_awvalid), .S_AXI_awready(S_AXI_awready),
        .S_AXI_wdata(S_AXI_wdata), .S_AXI_wstrb(S_AXI_wstrb), .S_AXI_wlast(S_AXI_wlast),
        .S_AXI_wvalid(S_AXI_wvalid), .S_AXI_wready(S_AXI_wready),
        .S_AXI_bid(S_AXI_bid), .S_AXI_bresp(S_AXI_bresp), .S_AXI_bvalid(S_AXI_bvalid),
        .S_AXI_bready(S_AXI_bready),
        .S_AXI_arid(S_AXI_arid), .S_AXI_araddr(S_AXI_araddr), .S_AXI_arlen(S_AXI_arlen),
        .S_AXI_arsize(S_AXI_arsize), .S_AXI_arburst(S_AXI_arburst),
        .S_AXI_arvalid(S_AXI_arvalid), .S_AXI_arready(S_AXI_arready),
        .S_AXI_rid(S_AXI_rid), .S_AXI_rdata(S_AXI_rdata), .S_AXI_rresp(S_AXI_rresp),
        .S_AXI_rlast(S_AXI_rlast), .S_AXI_rvalid(S_AXI_rvalid), .S_AXI_rready(S_AXI_rready)
    );

    always #5 ACLK = ~ACLK;

    int total = 0;
    int bad   = 0;

    logic [31:0] wbuf [16];
    logic [31:0] rdat [16];
    logic [1:0]  rrsp [16];
    logic        rlst [16];
    logic [31:0] expv [8];
    logic [1:0]  bresp_o;
    logic [3:0]  bid_o;
    int          nb;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Address phase then len+1 data beats then response; inputs change on falling edges.
    task automatic do_write(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                            input logic [1:0] burst, input logic [3:0] id, input logic [3:0] strb,
                            input logic badlast, output logic [1:0] resp, output logic [3:0] bid);
        int n;
        @(negedge ACLK);
        S_AXI_awid = id; S_AXI_awaddr = addr; S_AXI_awlen = len;
        S_AXI_awsize = size; S_AXI_awburst = burst; S_AXI_awvalid = 1'b1;
        n = 0;
        while (!S_AXI_awready && n < 50) begin @(negedge ACLK); n++; end
        check("aw_ready", S_AXI_awready, 1);
        @(negedge ACLK);
        S_AXI_awvalid = 1'b0;
        for (int i = 0; i <= int'(len); i++) begin
            S_AXI_wdata = wbuf[i]; S_AXI_wstrb = strb;
            S_AXI_wlast = (i == int'(len)) ^ badlast; S_AXI_wvalid = 1'b1;
            n = 0;
            while (!S_AXI_wready && n < 50) begin @(negedge ACLK); n++; end
            @(negedge ACLK);
        end
        S_AXI_wvalid = 1'b0; S_AXI_wlast = 1'b0;
        S_AXI_bready = 1'b1;
        n = 0;
        while (!S_AXI_bvalid && n < 50) begin @(negedge ACLK); n++; end
        check("b_valid", S_AXI_bvalid, 1);
        resp = S_AXI_bresp; bid = S_AXI_bid;
        @(negedge ACLK);
        S_AXI_bready = 1'b0;
    endtask

    // Collects beats into rdat/rrsp/rlst; with tog=1 rready alternates 1,0,1,0 and any
    // beat seen while stalled must still be there on the following cycle.
    task automatic do_read(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                           input logic [1:0] burst, input logic [3:0] id, input bit tog,
                           output int beats);
        int n, cyc;
        logic snap, sl;
        logic [31:0] sd;
        @(negedge ACLK);
        S_AXI_arid = id; S_AXI_araddr = addr; S_AXI_arlen = len;
        S_AXI_arsize = size; S_AXI_arburst = burst; S_AXI_arvalid = 1'b1;
        n = 0;
        while (!S_AXI_arready && n < 50) begin @(negedge ACLK); n++; end
        @(negedge ACLK);
        S_AXI_arvalid = 1'b0;
        check("r_first_cycle", S_AXI_rvalid, 1);
        check("r_id", S_AXI_rid, id);
        beats = 0; cyc = 0; snap = 1'b0; sd = '0; sl = 1'b0;
        while (beats <= int'(len) && cyc < 300) begin
            S_AXI_rready = tog ? ((cyc % 2) == 0) : 1'b1;
            if (snap) begin
                check("r_hold_data", S_AXI_rdata, sd);
                check("r_hold_last", S_AXI_rlast, sl);
                snap = 1'b0;
            end
            if (S_AXI_rvalid && S_AXI_rready) begin
                rdat[beats] = S_AXI_rdata; rrsp[beats] = S_AXI_rresp; rlst[beats] = S_AXI_rlast;
                beats++;
            end else if (S_AXI_rvalid) begin
                snap = 1'b1; sd = S_AXI_rdata; sl = S_AXI_rlast;
            end
            @(negedge ACLK);
            cyc++;
        end
        S_AXI_rready = 1'b0;
        check("r_no_extra_beat", S_AXI_rvalid, 0);
    endtask

    initial begin
        ARESETN = 1'b0;
        S_AXI_awid = '0; S_AXI_awaddr = '0; S_AXI_awlen = '0; S_AXI_awsize = '0;
        S_AXI_awburst = '0; S_AXI_awvalid = 1'b0;
        S_AXI_wdata = '0; S_AXI_wstrb = '0; S_AXI_wlast = 1'b0; S_AXI_wvalid = 1'b0;
        S_AXI_bready = 1'b0;
        S_AXI_arid = '0; S_AXI_araddr = '0; S_AXI_arlen = '0; S_AXI_arsize = '0;
        S_AXI_arburst = '0; S_AXI_arvalid = 1'b0; S_AXI_rready = 1'b0;
        repeat (3) @(negedge ACLK);

        // Reset values
        check("rst_awready", S_AXI_awready, 1);
        check("rst_arready", S_AXI_arready, 1);
        check("rst_wready", S_AXI_wready, 0);
        check("rst_bvalid", S_AXI_bvalid, 0);
        check("rst_rvalid", S_AXI_rvalid, 0);
        check("rst_rlast", S_AXI_rlast, 0);
        check("rst_bresp", S_AXI_bresp, 0);
        check("rst_rresp", S_AXI_rresp, 0);
        check("rst_bid", S_AXI_bid, 0);
        check("rst_rid", S_AXI_rid, 0);
        check("rst_rdata", S_AXI_rdata, 0);
        ARESETN = 1'b1;

        // INCR write/read 0x10..0x1C
        for (int i = 0; i < 4; i++) wbuf[i] = 32'hA0 + i;
        do_write(32'h10, 8'd3, 3'd2, 2'b01, 4'h5, 4'hF, 1'b0, bresp_o, bid_o);
        check("incr_bresp", bresp_o, 2'b00);
        check("incr_bid", bid_o, 4'h5);
        do_read(32'h10, 8'd3, 3'd2, 2'b01, 4'h3, 1'b0, nb);
        check("incr_nbeats", nb, 4);
        for (int i = 0; i < 4; i++) begin
            check("incr_rdata", rdat[i], 32'hA0 + i);
            check("incr_rlast", rlst[i], (i == 3));
            check("incr_rresp", rrsp[i], 2'b00);
        end

        // WRAP from 0x18: words 6,7,4,5
        expv[0] = 32'hA2; expv[1] = 32'hA3; expv[2] = 32'hA0; expv[3] = 32'hA1;
        do_read(32'h18, 8'd3, 3'd2, 2'b10, 4'h1, 1'b0, nb);
        for (int i = 0; i < 4; i++) check("wrap_rdata", rdat[i], expv[i]);

        // Byte strobes
        wbuf[0] = 32'h11223344;
        do_write(32'h0, 8'd0, 3'd2, 2'b01, 4'h2, 4'hF, 1'b0, bresp_o, bid_o);
        wbuf[0] = 32'hFFFFFFFF;
        do_write(32'h0, 8'd0, 3'd2, 2'b01, 4'h2, 4'b0101, 1'b0, bresp_o, bid_o);
        do_read(32'h0, 8'd0, 3'd2, 2'b01, 4'h2, 1'b0, nb);
        check("strb_rdata", rdat[0], 32'h11FF33FF);

        // Out of range at 0x1000, must not alias onto word 0
        wbuf[0] = 32'hDEAD0000; wbuf[1] = 32'hDEAD0001;
        do_write(32'h1000, 8'd1, 3'd2, 2'b01, 4'h7, 4'hF, 1'b0, bresp_o, bid_o);
        check("oor_bresp", bresp_o, 2'b10);
        do_read(32'h0, 8'd0, 3'd2, 2'b01, 4'h0, 1'b0, nb);
        check("oor_mem_unchanged", rdat[0], 32'h11FF33FF);
        do_read(32'h1000, 8'd1, 3'd2, 2'b01, 4'h4, 1'b0, nb);
        check("oor_nbeats", nb, 2);
        for (int i = 0; i < 2; i++) begin
            check("oor_rdata", rdat[i], 0);
            check("oor_rresp", rrsp[i], 2'b10);
        end

        // Window edges: last word is legal, a burst running past it is not
        wbuf[0] = 32'hCAFE0001;
        do_write(32'hFFC, 8'd0, 3'd2, 2'b01, 4'h1, 4'hF, 1'b0, bresp_o, bid_o);
        check("edge_bresp", bresp_o, 2'b00);
        do_read(32'hFFC, 8'd0, 3'd2, 2'b01, 4'h1, 1'b0, nb);
        check("edge_rdata", rdat[0], 32'hCAFE0001);
        check("edge_rresp", rrsp[0], 2'b00);
        do_read(32'hFF8, 8'd3, 3'd2, 2'b01, 4'h1, 1'b0, nb);
        check("cross_rresp", rrsp[0], 2'b10);

        // Illegal burst shapes
        do_read(32'h10, 8'd3, 3'd2, 2'b11, 4'h1, 1'b0, nb);
        check("rsvd_burst_rresp", rrsp[0], 2'b10);
        do_read(32'h10, 8'd2, 3'd2, 2'b10, 4'h1, 1'b0, nb);
        check("wrap_len2_rresp", rrsp[0], 2'b10);
        do_read(32'h10, 8'd0, 3'd3, 2'b01, 4'h1, 1'b0, nb);
        check("big_size_rresp", rrsp[0], 2'b10);
        check("big_size_rdata", rdat[0], 0);

        // FIXED write keeps hitting one word
        wbuf[0] = 32'hC0; wbuf[1] = 32'hC1; wbuf[2] = 32'hC2;
        do_write(32'h100, 8'd2, 3'd2, 2'b00, 4'h9, 4'hF, 1'b0, bresp_o, bid_o);
        check("fixed_bresp", bresp_o, 2'b00);
        do_read(32'h100, 8'd0, 3'd2, 2'b01, 4'h9, 1'b0, nb);
        check("fixed_rdata", rdat[0], 32'hC2);

        // Misplaced wlast: data stored, response SLVERR
        wbuf[0] = 32'hE0; wbuf[1] = 32'hE1;
        do_write(32'h80, 8'd1, 3'd2, 2'b01, 4'h6, 4'hF, 1'b1, bresp_o, bid_o);
        check("wlast_bresp", bresp_o, 2'b10);
        do_read(32'h80, 8'd1, 3'd2, 2'b01, 4'h6, 1'b0, nb);
        check("wlast_rdata0", rdat[0], 32'hE0);
        check("wlast_rdata1", rdat[1], 32'hE1);

        // Backpressure on an 8-beat read
        for (int i = 0; i < 8; i++) wbuf[i] = 32'hB0 + i;
        do_write(32'h40, 8'd7, 3'd2, 2'b01, 4'h3, 4'hF, 1'b0, bresp_o, bid_o);
        do_read(32'h40, 8'd7, 3'd2, 2'b01, 4'hA, 1'b1, nb);
        check("bp_nbeats", nb, 8);
        for (int i = 0; i < 8; i++) begin
            check("bp_rdata", rdat[i], 32'hB0 + i);
            check("bp_rlast", rlst[i], (i == 7));
        end

        // Overlapping write and read bursts
        for (int i = 0; i < 4; i++) wbuf[i] = 32'hD0 + i;
        fork
            do_write(32'h200, 8'd3, 3'd2, 2'b01, 4'hC, 4'hF, 1'b0, bresp_o, bid_o);
            do_read(32'h40, 8'd3, 3'd2, 2'b01, 4'hD, 1'b0, nb);
        join
        check("conc_bresp", bresp_o, 2'b00);
        for (int i = 0; i < 4; i++) check("conc_rdata", rdat[i], 32'hB0 + i);
        do_read(32'h200, 8'd3, 3'd2, 2'b01, 4'hD, 1'b0, nb);
        for (int i = 0; i < 4; i++) check("conc_wdata", rdat[i], 32'hD0 + i);

        // Reset pulse while beat 2 of a read is on the bus
        @(negedge ACLK);
        S_AXI_arid = 4'h2; S_AXI_araddr = 32'h40; S_AXI_arlen = 8'd7;
        S_AXI_arsize = 3'd2; S_AXI_arburst = 2'b01; S_AXI_arvalid = 1'b1;
        @(negedge ACLK);
        S_AXI_arvalid = 1'b0; S_AXI_rready = 1'b1;
        @(negedge ACLK);
        @(negedge ACLK);
        check("rst_mid_beat2", S_AXI_rdata, 32'hB2);
        ARESETN = 1'b0; S_AXI_rready = 1'b0;
        @(posedge ACLK);
        #1;
        check("rst_mid_rvalid", S_AXI_rvalid, 0);
        check("rst_mid_arready", S_AXI_arready, 1);
        @(negedge ACLK);
        ARESETN = 1'b1;
        do_read(32'h40, 8'd0, 3'd2, 2'b01, 4'h2, 1'b0, nb);
        check("rst_mem_retained", rdat[0], 32'hB0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
